// File: rtl/percept_pkg.sv
// Shared definitions for the perceptron array control bus: opcodes,
// serial line levels and the command transmitter FSM states.
// Optional feature macro: PERCEPT_TX_PARITY_EN adds a PARITY state.
package percept_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] OUT_DATA1 = 3'd0;
    localparam logic [OPCODE_W-1:0] OUT_DATA2 = 3'd1;
    localparam logic [OPCODE_W-1:0] OUT_RES   = 3'd2;
    localparam logic [OPCODE_W-1:0] LOAD      = 3'd3;
    localparam logic [OPCODE_W-1:0] LOAD_RES  = 3'd4;
    localparam logic [OPCODE_W-1:0] MUL       = 3'd5;
    localparam logic [OPCODE_W-1:0] MUL_ADD   = 3'd6;
    localparam logic [OPCODE_W-1:0] NO_OP     = 3'd7;

    localparam logic START_BIT  = 1'b0;
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef PERCEPT_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_ADDR   = 3'd2,
        S_OP     = 3'd3,
        S_PARITY = 3'd4,
        S_GAP    = 3'd5
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_ADDR   = 3'd2,
        S_OP     = 3'd3,
        S_GAP    = 3'd5
    } tx_state_e;
`endif

endpackage

// File: rtl/percept_cmd_tx_if.sv
// Command handshake bundle between the host and the serial command transmitter.
interface percept_cmd_tx_if
    import percept_pkg::*;
#(
    parameter int ADDR_W = 9
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [OPCODE_W-1:0] cmd_op;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_op,
        output cmd_ready
    );

endinterface

// File: rtl/percept_bit_timer.sv
// Serial bit timer: divides clk into bit periods of BIT_CYCLES clocks and
// emits a one-cycle bit_tick_o at the end of each period while running.
module percept_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic nRst,
    input  logic restart_i,
    input  logic run_i,
    output logic bit_tick_o
);

    localparam int TW = ($clog2(BIT_CYCLES + 1) < 1) ? 1 : $clog2(BIT_CYCLES + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign bit_tick_o = run_i && (cnt_q == TW'(BIT_CYCLES - 1));

    // Next count: restart aligns the first bit period with the accept edge.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = bit_tick_o ? '0 : cnt_q + TW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/percept_cmd_tx.sv
// Host-side serial command transmitter. Serialises {address, opcode} onto an
// idle-high line: start bit, address MSB-first, opcode MSB-first, optional
// even parity, then GAP_BITS idle bits.
// Optional feature macro: PERCEPT_TX_PARITY_EN.
module percept_cmd_tx
    import percept_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_BITS   = 4
) (
    input  logic              clk,
    input  logic              nRst,
    percept_cmd_tx_if.slave   cmd,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int FRAME_W  = ADDR_W + OPCODE_W;
    localparam int CNT_MAX0 = (ADDR_W > GAP_BITS) ? ADDR_W : GAP_BITS;
    localparam int CNT_MAX  = (CNT_MAX0 > OPCODE_W) ? CNT_MAX0 : OPCODE_W;
    localparam int CNT_W    = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    tx_state_e          state_q, state_d;
    logic               tx_q, tx_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic               accept;
    logic               bitTick;
`ifdef PERCEPT_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    assign accept        = (state_q == S_IDLE) && cmd.cmd_valid;
    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign tx            = tx_q;
    assign done          = (state_q == S_GAP) && bitTick &&
                           (bitCnt_q == CNT_W'(GAP_BITS - 1));

    percept_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk        (clk),
        .nRst       (nRst),
        .restart_i  (accept),
        .run_i      (busy),
        .bit_tick_o (bitTick)
    );

    // Next-state logic: tx_d is the level for the next bit period, so tx
    // stays a pure register and the start bit appears right after accept.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        shift_d  = shift_q;
        bitCnt_d = bitCnt_q;
`ifdef PERCEPT_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = IDLE_LEVEL;
                if (cmd.cmd_valid) begin
                    state_d  = S_START;
                    tx_d     = START_BIT;
                    shift_d  = {cmd.cmd_addr, cmd.cmd_op};
                    bitCnt_d = '0;
`ifdef PERCEPT_TX_PARITY_EN
                    parity_d = ^{cmd.cmd_addr, cmd.cmd_op};
`endif
                end
            end
            S_START: begin
                if (bitTick) begin
                    state_d  = S_ADDR;
                    tx_d     = shift_q[FRAME_W-1];
                    shift_d  = shift_q << 1;
                    bitCnt_d = '0;
                end
            end
            S_ADDR: begin
                if (bitTick) begin
                    tx_d    = shift_q[FRAME_W-1];
                    shift_d = shift_q << 1;
                    if (bitCnt_q == CNT_W'(ADDR_W - 1)) begin
                        state_d  = S_OP;
                        bitCnt_d = '0;
                    end else begin
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end
            end
            S_OP: begin
                if (bitTick) begin
                    if (bitCnt_q == CNT_W'(OPCODE_W - 1)) begin
                        bitCnt_d = '0;
`ifdef PERCEPT_TX_PARITY_EN
                        state_d  = S_PARITY;
                        tx_d     = parity_q;
`else
                        state_d  = S_GAP;
                        tx_d     = IDLE_LEVEL;
`endif
                    end else begin
                        tx_d     = shift_q[FRAME_W-1];
                        shift_d  = shift_q << 1;
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef PERCEPT_TX_PARITY_EN
            S_PARITY: begin
                if (bitTick) begin
                    state_d  = S_GAP;
                    tx_d     = IDLE_LEVEL;
                    bitCnt_d = '0;
                end
            end
`endif
            S_GAP: begin
                tx_d = IDLE_LEVEL;
                if (bitTick) begin
                    if (bitCnt_q == CNT_W'(GAP_BITS - 1)) begin
                        state_d  = S_IDLE;
                        bitCnt_d = '0;
                    end else begin
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                tx_d     = IDLE_LEVEL;
                bitCnt_d = '0;
            end
        endcase
    end

    // State, line and shift registers; reset drops any frame and idles the line.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= S_IDLE;
            tx_q     <= IDLE_LEVEL;
            shift_q  <= '0;
            bitCnt_q <= '0;
`ifdef PERCEPT_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
`ifdef PERCEPT_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
